// File: rtl/shifter_operand_unit.sv
`default_nettype none
// ============================================================================
// Module   : shifter_operand_unit
// Brief    : Two-stage pipelined ARM operand-2 barrel shifter with carry-out.
// Revision : 1.0
// ============================================================================
module shifter_operand_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [1:0]       in_type,
    input  logic [7:0]       in_imm8,
    input  logic [3:0]       in_rotate_imm,
    input  logic [4:0]       in_shift_imm,
    input  logic [WIDTH-1:0] in_rm,
    input  logic [WIDTH-1:0] in_rs,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry
);

    // Amount field is wide enough to hold WIDTH itself (LSR/ASR #0 encodings).
    localparam int                 c_AMT_W  = (AW + 1 > 9) ? AW + 1 : 9;
    localparam logic [c_AMT_W-1:0] c_W_AMT  = c_AMT_W'(WIDTH);
    localparam logic [31:0]        c_W32    = 32'(WIDTH);
    localparam logic [AW-1:0]      c_ONE    = AW'(1);
    localparam logic [1:0]         c_M_ROT  = 2'b00;
    localparam logic [1:0]         c_M_IMM  = 2'b01;
    localparam logic [1:0]         c_M_REG  = 2'b10;
    localparam logic [1:0]         c_T_LSL  = 2'b00;
    localparam logic [1:0]         c_T_LSR  = 2'b01;
    localparam logic [1:0]         c_T_ASR  = 2'b10;
    localparam logic [1:0]         c_T_ROR  = 2'b11;

    logic               r_s1_valid, r_s2_valid;
    logic [WIDTH-1:0]   r_s1_src;
    logic [1:0]         r_s1_type;
    logic [c_AMT_W-1:0] r_s1_amt;
    logic               r_s1_cin, r_s1_pass, r_s1_rrx;
    logic [WIDTH-1:0]   r_s2_result;
    logic               r_s2_carry;

    logic               w_s2_adv, w_s1_adv;
    logic [WIDTH-1:0]   w_src;
    logic [1:0]         w_type;
    logic [c_AMT_W-1:0] w_amt;
    logic               w_pass, w_rrx;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // Decode: normalise every mode onto (source, type, amount) plus two
    // special cases (pass-through with carry-in, and RRX).
    always_comb begin
        w_src  = in_rm;
        w_type = in_type;
        w_amt  = '0;
        w_pass = 1'b0;
        w_rrx  = 1'b0;
        case (in_mode)
            c_M_ROT: begin
                w_src  = {{(WIDTH-8){1'b0}}, in_imm8};
                w_type = c_T_ROR;
                w_amt  = c_AMT_W'({in_rotate_imm, 1'b0});
                w_pass = (in_rotate_imm == 4'd0);
            end
            c_M_IMM: begin
                w_amt = c_AMT_W'(in_shift_imm);
                if (in_shift_imm == 5'd0) begin
                    case (in_type)
                        c_T_LSL: w_pass = 1'b1;
                        c_T_ROR: w_rrx  = 1'b1;
                        default: w_amt  = c_W_AMT;
                    endcase
                end
            end
            c_M_REG: begin
                w_amt  = c_AMT_W'(in_rs[7:0]);
                w_pass = (in_rs[7:0] == 8'd0);
            end
            default: w_pass = 1'b1;
        endcase
    end

    logic [31:0]        w_amt32;
    logic [AW-1:0]      w_lo, w_dec, w_neg;
    logic               w_lt, w_eq, w_sign;
    logic [2*WIDTH-1:0] w_ror_full;
    logic [WIDTH-1:0]   w_asr, w_res;
    logic               w_cout;

    assign w_amt32    = 32'(r_s1_amt);
    assign w_lo       = r_s1_amt[AW-1:0];
    assign w_dec      = w_lo - c_ONE;
    assign w_neg      = ~w_lo + c_ONE;
    assign w_lt       = w_amt32 < c_W32;
    assign w_eq       = w_amt32 == c_W32;
    assign w_sign     = r_s1_src[WIDTH-1];
    assign w_ror_full = {r_s1_src, r_s1_src} >> w_lo;
    assign w_asr      = $signed(r_s1_src) >>> w_lo;

    // Shift stage. Indices w_dec/w_neg are only meaningful for 1 <= n < WIDTH;
    // n==0 never reaches the shift paths because decode flags it as pass.
    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        case (r_s1_type)
            c_T_LSL: begin
                if (w_lt) begin
                    w_res  = r_s1_src << w_lo;
                    w_cout = r_s1_src[w_neg];
                end else if (w_eq) begin
                    w_cout = r_s1_src[0];
                end
            end
            c_T_LSR: begin
                if (w_lt) begin
                    w_res  = r_s1_src >> w_lo;
                    w_cout = r_s1_src[w_dec];
                end else if (w_eq) begin
                    w_cout = w_sign;
                end
            end
            c_T_ASR: begin
                if (w_lt) begin
                    w_res  = w_asr;
                    w_cout = r_s1_src[w_dec];
                end else begin
                    w_res  = {WIDTH{w_sign}};
                    w_cout = w_sign;
                end
            end
            default: begin
                w_res  = w_ror_full[WIDTH-1:0];
                w_cout = w_ror_full[WIDTH-1];
            end
        endcase
        if (r_s1_rrx) begin
            w_res  = {r_s1_cin, r_s1_src[WIDTH-1:1]};
            w_cout = r_s1_src[0];
        end
        if (r_s1_pass) begin
            w_res  = r_s1_src;
            w_cout = r_s1_cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s1_src    <= '0;
            r_s1_type   <= 2'b00;
            r_s1_amt    <= '0;
            r_s1_cin    <= 1'b0;
            r_s1_pass   <= 1'b0;
            r_s1_rrx    <= 1'b0;
            r_s2_result <= '0;
            r_s2_carry  <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_src  <= w_src;
                    r_s1_type <= w_type;
                    r_s1_amt  <= w_amt;
                    r_s1_cin  <= in_c;
                    r_s1_pass <= w_pass;
                    r_s1_rrx  <= w_rrx;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_result <= w_res;
                    r_s2_carry  <= w_cout;
                end
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_carry  = r_s2_carry;

endmodule
`default_nettype wire

// File: tb/tb_shifter_operand_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_operand_unit
// Brief    : Scoreboard bench for shifter_operand_unit (WIDTH=32).
// Revision : 1.0
// ============================================================================
module tb_shifter_operand_unit;

    typedef struct packed {
        logic [1:0]  mode;
        logic [1:0]  typ;
        logic [7:0]  imm8;
        logic [3:0]  rot;
        logic [4:0]  sh;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        c;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = '0;
    logic [1:0]  in_type = '0;
    logic [7:0]  in_imm8 = '0;
    logic [3:0]  in_rotate_imm = '0;
    logic [4:0]  in_shift_imm = '0;
    logic [31:0] in_rm = '0;
    logic [31:0] in_rs = '0;
    logic        in_c = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_carry;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] q[$];
    bit          r_rand = 1'b0;

    shifter_operand_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_type(in_type), .in_imm8(in_imm8),
        .in_rotate_imm(in_rotate_imm), .in_shift_imm(in_shift_imm),
        .in_rm(in_rm), .in_rs(in_rs), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] reg_rule(input logic [1:0] t, input int n, input logic [31:0] rm);
        logic [63:0] e;
        logic [31:0] r;
        int          k;
        case (t)
            2'd0: begin
                if (n < 32) begin e = {32'd0, rm} << n; return {e[32], e[31:0]}; end
                else if (n == 32) return {rm[0], 32'd0};
                else return 33'd0;
            end
            2'd1: begin
                if (n < 32) begin e = {rm, 32'd0} >> n; return {e[31], e[63:32]}; end
                else if (n == 32) return {rm[31], 32'd0};
                else return 33'd0;
            end
            2'd2: begin
                if (n < 32) begin e = $signed({rm, 32'd0}) >>> n; return {e[31], e[63:32]}; end
                else return {rm[31], {32{rm[31]}}};
            end
            default: begin
                k = n % 32;
                if (k == 0) return {rm[31], rm};
                r = (rm >> k) | (rm << (32 - k));
                return {r[31], r};
            end
        endcase
    endfunction

    function automatic logic [32:0] model(input op_t o);
        logic [31:0] v;
        int          k;
        case (o.mode)
            2'd0: begin
                v = {24'd0, o.imm8};
                k = 2 * int'(o.rot);
                if (k == 0) return {o.c, v};
                v = (v >> k) | (v << (32 - k));
                return {v[31], v};
            end
            2'd1: begin
                if (o.sh != 5'd0) return reg_rule(o.typ, int'(o.sh), o.rm);
                case (o.typ)
                    2'd0:    return {o.c, o.rm};
                    2'd3:    return {o.rm[0], o.c, o.rm[31:1]};
                    default: return reg_rule(o.typ, 32, o.rm);
                endcase
            end
            2'd2: begin
                if (o.rs[7:0] == 8'd0) return {o.c, o.rm};
                return reg_rule(o.typ, int'(o.rs[7:0]), o.rm);
            end
            default: return {o.c, o.rm};
        endcase
    endfunction

    function automatic op_t mk(input logic [1:0] m, input logic [1:0] t, input logic [7:0] i8,
                               input logic [3:0] ro, input logic [4:0] s, input logic [31:0] rm,
                               input logic [31:0] rs, input logic c);
        op_t o;
        o.mode = m; o.typ = t; o.imm8 = i8; o.rot = ro; o.sh = s; o.rm = rm; o.rs = rs; o.c = c;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.mode = 2'($urandom_range(0, 3));
        o.typ  = 2'($urandom_range(0, 3));
        o.imm8 = 8'($urandom);
        o.rot  = 4'($urandom);
        o.sh   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        o.rm   = $urandom;
        o.rs   = ($urandom_range(0, 3) == 0) ? $urandom
               : (($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 70)));
        o.c    = 1'($urandom);
        return o;
    endfunction

    task automatic apply(input op_t o);
        in_mode = o.mode; in_type = o.typ; in_imm8 = o.imm8; in_rotate_imm = o.rot;
        in_shift_imm = o.sh; in_rm = o.rm; in_rs = o.rs; in_c = o.c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (r_rand) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Offers one op until accepted; expected value is either given or modelled.
    task automatic send(input op_t o, input bit has_exp, input logic [32:0] exp);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        apply(o);
        in_valid = 1'b1;
        while (!acc && t < 100) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                if (!flush) q.push_back(has_exp ? exp : model(o));
            end
            tick();
            t++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin tick(); t++; end
        if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
            else check("result", {31'd0, out_carry, out_result}, {31'd0, q.pop_front()});
        end
    end

    initial begin
        op_t         bp[4];
        logic [32:0] hold;
        int          acc, nv;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Directed vectors with hand-derived results; first one also times latency.
        out_ready = 1'b1;
        send(mk(2'd0, 2'd0, 8'hFF, 4'd4, 5'd0, 32'h0, 32'h0, 1'b0), 1, {1'b1, 32'hFF00_0000});
        @(negedge clk);
        check("lat_s1", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("lat_s2", 64'(out_valid), 64'd1);
        tick();
        send(mk(2'd0, 2'd0, 8'hFF, 4'd0, 5'd0, 32'h0, 32'h0, 1'b1), 1, {1'b1, 32'h0000_00FF});
        send(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'h8000_0001, 32'd32, 1'b0), 1, {1'b1, 32'h0});
        send(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'h8000_0001, 32'd33, 1'b0), 1, {1'b0, 32'h0});
        send(mk(2'd2, 2'd1, 8'h0, 4'd0, 5'd0, 32'h8000_0001, 32'd32, 1'b0), 1, {1'b1, 32'h0});
        send(mk(2'd2, 2'd2, 8'h0, 4'd0, 5'd0, 32'h8000_0001, 32'd40, 1'b0), 1, {1'b1, 32'hFFFF_FFFF});
        send(mk(2'd2, 2'd3, 8'h0, 4'd0, 5'd0, 32'h8000_0001, 32'd36, 1'b0), 1, {1'b0, 32'h1800_0000});
        send(mk(2'd2, 2'd1, 8'h0, 4'd0, 5'd0, 32'h8000_0001, 32'h100, 1'b1), 1, {1'b1, 32'h8000_0001});
        send(mk(2'd1, 2'd3, 8'h0, 4'd0, 5'd0, 32'h3, 32'h0, 1'b1), 1, {1'b1, 32'h8000_0001});
        send(mk(2'd1, 2'd1, 8'h0, 4'd0, 5'd0, 32'h3, 32'h0, 1'b1), 1, {1'b0, 32'h0});
        send(mk(2'd1, 2'd2, 8'h0, 4'd0, 5'd0, 32'h8000_0000, 32'h0, 1'b1), 1, {1'b1, 32'hFFFF_FFFF});
        send(mk(2'd1, 2'd0, 8'h0, 4'd0, 5'd4, 32'h1234_5678, 32'h0, 1'b0), 1, {1'b1, 32'h2345_6780});
        send(mk(2'd3, 2'd2, 8'h0, 4'd0, 5'd0, 32'h1234_5678, 32'h0, 1'b1), 1, {1'b1, 32'h1234_5678});
        drain();

        // Random stream with random backpressure, checked against the model.
        r_rand = 1'b1;
        repeat (300) send(rand_op(), 0, 33'd0);
        drain();
        r_rand = 1'b0;

        // Backpressure: 4 ops offered with out_ready low.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bp[i] = mk(2'd2, 2'(i), 8'h0, 4'd0, 5'd0, 32'hC000_0003 + 32'(i), 32'(i + 1), 1'b0);
        tick();
        acc = 0;
        apply(bp[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready && acc < 4) begin q.push_back(model(bp[acc])); acc++; end
            tick();
            if (acc < 4) apply(bp[acc]);
        end
        check("bp_accepts", 64'(acc), 64'd2);
        @(negedge clk);
        check("bp_full", 64'(in_ready), 64'd0);
        hold = {out_carry, out_result};
        tick();
        @(negedge clk);
        check("bp_stable", {31'd0, out_carry, out_result}, {31'd0, hold});
        tick();
        out_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nv += int'(out_valid);
            if (in_ready && acc < 4) begin q.push_back(model(bp[acc])); acc++; end
            tick();
            if (acc < 4) apply(bp[acc]); else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stream", 64'(nv), 64'd4);
        drain();

        // Flush with both stages full and a third op offered.
        out_ready = 1'b0;
        send(mk(2'd3, 2'd0, 8'h0, 4'd0, 5'd0, 32'hAAAA_0001, 32'h0, 1'b1), 0, 33'd0);
        send(mk(2'd3, 2'd0, 8'h0, 4'd0, 5'd0, 32'hAAAA_0002, 32'h0, 1'b0), 0, 33'd0);
        apply(mk(2'd3, 2'd0, 8'h0, 4'd0, 5'd0, 32'hAAAA_0003, 32'h0, 1'b1));
        in_valid  = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("fl_no_out", 64'(out_valid), 64'd0);
            tick();
        end
        send(mk(2'd2, 2'd3, 8'h0, 4'd0, 5'd0, 32'h0000_00F0, 32'd4, 1'b0), 1, {1'b0, 32'h0000_000F});
        @(negedge clk);
        check("fl_lat_s1", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("fl_lat_s2", 64'(out_valid), 64'd1);
        tick();
        drain();

        // Asynchronous reset with both stages valid.
        out_ready = 1'b0;
        send(mk(2'd3, 2'd0, 8'h0, 4'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b1), 0, 33'd0);
        send(mk(2'd3, 2'd0, 8'h0, 4'd0, 5'd0, 32'hCAFE_F00D, 32'h0, 1'b1), 0, 33'd0);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_out_result", 64'(out_result), 64'd0);
        check("ar_out_carry", 64'(out_carry), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ar_no_out", 64'(out_valid), 64'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
